// File: rtl/tex_bus_arbiter_pkg.sv
// Shared definitions for the texture bus arbiter: field widths of the
// texture request payload and the tag layout used on the shared bus.
package tex_bus_arbiter_pkg;

  localparam int TEX_LOD_BITS      = 4;
  localparam int TEX_STAGE_BITS    = 2;
  localparam int TEX_REQ_TAG_WIDTH = 8;

  // Tag layout on the shared texture-unit side (tex_arb_tag_t):
  //   [TAG_WIDTH+SEL_BITS-1 : SEL_BITS]  original requester tag
  //   [SEL_BITS-1 : 0]                   requester index (absent when SEL_BITS==0)
  function automatic int tex_arb_sel_bits(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 0;
  endfunction

endpackage

// File: rtl/tex_pending_ctr.sv
// Outstanding-request counter for one requester: counts up on request
// accept, down on response accept, and flags when the limit is reached.
module tex_pending_ctr #(
  parameter int MAX_PENDING = 8,
  parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full
);

  logic [CNT_W-1:0] r_count;

  // Up/down count; simultaneous inc and dec cancel, and the count never wraps.
  // NOTE: state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && r_count != CNT_W'(MAX_PENDING)) begin
      r_count <= r_count + CNT_W'(1);
    end else if (i_dec && !i_inc && r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_full = (r_count == CNT_W'(MAX_PENDING));

  // A response for a requester with nothing outstanding is a system bug.
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    i_dec |-> (r_count != '0));

endmodule

// File: rtl/tex_bus_arbiter.sv
// Round-robin arbiter sharing one texture-unit bus among NUM_REQS agents.
// Requests are tagged with the requester index in the tag LSBs; responses
// are routed back by that index and the index is stripped again.
module tex_bus_arbiter
  import tex_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQS    = 4,
  parameter int NUM_LANES   = 4,
  parameter int REQ_DATAW   = NUM_LANES * (64 + TEX_LOD_BITS) + TEX_STAGE_BITS,
  parameter int TAG_WIDTH   = TEX_REQ_TAG_WIDTH,
  parameter int MAX_PENDING = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             req_valid_in,
  input  logic [NUM_REQS*NUM_LANES-1:0]   req_mask_in,
  input  logic [NUM_REQS*REQ_DATAW-1:0]   req_data_in,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]   req_tag_in,
  output logic [NUM_REQS-1:0]             req_ready_in,
  output logic                            req_valid_out,
  output logic [NUM_LANES-1:0]            req_mask_out,
  output logic [REQ_DATAW-1:0]            req_data_out,
  output logic [TAG_WIDTH+tex_arb_sel_bits(NUM_REQS)-1:0] req_tag_out,
  input  logic                            req_ready_out,
  input  logic                            rsp_valid_in,
  input  logic [NUM_LANES*32-1:0]         rsp_texels_in,
  input  logic [TAG_WIDTH+tex_arb_sel_bits(NUM_REQS)-1:0] rsp_tag_in,
  output logic                            rsp_ready_in,
  output logic [NUM_REQS-1:0]             rsp_valid_out,
  output logic [NUM_REQS*NUM_LANES*32-1:0] rsp_texels_out,
  output logic [NUM_REQS*TAG_WIDTH-1:0]   rsp_tag_out,
  input  logic [NUM_REQS-1:0]             rsp_ready_out
);

  localparam int SEL_BITS  = tex_arb_sel_bits(NUM_REQS);
  localparam int SEL_W     = (SEL_BITS > 0) ? SEL_BITS : 1;
  localparam int TAG_OUT_W = TAG_WIDTH + SEL_BITS;
  localparam int CNT_W     = $clog2(MAX_PENDING + 1);
  localparam int REQ_W     = TAG_OUT_W + NUM_LANES + REQ_DATAW;
  localparam int RSP_W     = TAG_WIDTH + NUM_LANES * 32;

  logic [NUM_REQS-1:0]  w_full;
  logic [NUM_REQS-1:0]  w_eligible;
  logic [NUM_REQS-1:0]  w_rsp_in_valid;
  logic [NUM_REQS-1:0]  w_rsp_buf_ready;
  logic [NUM_REQS-1:0]  w_rsp_fire;
  logic [SEL_W-1:0]     w_grant;
  logic                 w_grant_valid;
  logic                 w_req_buf_ready;
  logic                 w_req_fire;
  logic [TAG_WIDTH-1:0] w_req_tag_raw;
  logic [TAG_OUT_W-1:0] w_req_tag;
  logic [REQ_W-1:0]     w_req_in_data;
  logic [SEL_W-1:0]     w_rsp_sel;
  logic [TAG_WIDTH-1:0] w_rsp_tag;
  logic [RSP_W-1:0]     w_rsp_in_data;

  assign w_eligible = req_valid_in & ~w_full;
  assign w_req_fire = w_grant_valid && w_req_buf_ready;

  // ---------------------------------------------------------------- arbiter
  if (NUM_REQS > 1) begin : g_arb
    logic [SEL_W-1:0] r_ptr;

    // First eligible requester at or after the pointer wins; scanning from the
    // far end lets the nearest candidate overwrite the others.
    // NOTE: every output is defaulted first so no path infers a latch.
    always_comb begin
      w_grant       = '0;
      w_grant_valid = 1'b0;
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
        if (w_eligible[(int'(r_ptr) + k) % NUM_REQS]) begin
          w_grant       = SEL_W'((int'(r_ptr) + k) % NUM_REQS);
          w_grant_valid = 1'b1;
        end
      end
    end

    // Pointer moves past the winner only when its request is accepted.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_ptr <= '0;
      end else if (w_req_fire) begin
        r_ptr <= (w_grant == SEL_W'(NUM_REQS - 1)) ? '0 : w_grant + SEL_W'(1);
      end
    end

    assign w_req_tag = {w_req_tag_raw, w_grant};
    assign w_rsp_sel = rsp_tag_in[SEL_BITS-1:0];
  end else begin : g_single
    assign w_grant       = '0;
    assign w_grant_valid = w_eligible[0];
    assign w_req_tag     = w_req_tag_raw;
    assign w_rsp_sel     = '0;
  end

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_ready
    assign req_ready_in[gi] = w_grant_valid && (w_grant == SEL_W'(gi)) && w_req_buf_ready;
  end

  assign w_req_tag_raw = req_tag_in[w_grant*TAG_WIDTH +: TAG_WIDTH];
  assign w_req_in_data = {w_req_tag,
                          req_mask_in[w_grant*NUM_LANES +: NUM_LANES],
                          req_data_in[w_grant*REQ_DATAW +: REQ_DATAW]};

  // ------------------------------------------------ request elastic buffer
  logic             r_req_valid;
  logic             r_req_skid_valid;
  logic [REQ_W-1:0] r_req_data;
  logic [REQ_W-1:0] r_req_skid_data;

  assign w_req_buf_ready = !r_req_skid_valid;

  // Output slot refills from the skid slot first; skid catches one accept
  // while the output is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_valid      <= 1'b0;
      r_req_skid_valid <= 1'b0;
    end else if (!r_req_valid || req_ready_out) begin
      r_req_valid      <= r_req_skid_valid || w_req_fire;
      r_req_skid_valid <= 1'b0;
    end else if (w_req_fire) begin
      r_req_skid_valid <= 1'b1;
    end
  end

  // Payload registers follow the valid bits.
  // NOTE: datapath flops carry no reset; their contents only matter under valid.
  always_ff @(posedge clk) begin
    if (!r_req_valid || req_ready_out) begin
      r_req_data <= r_req_skid_valid ? r_req_skid_data : w_req_in_data;
    end else if (w_req_fire) begin
      r_req_skid_data <= w_req_in_data;
    end
  end

  assign req_valid_out = r_req_valid;
  assign {req_tag_out, req_mask_out, req_data_out} = r_req_data;

  // ------------------------------------------------- response routing
  assign w_rsp_tag     = rsp_tag_in[TAG_OUT_W-1 -: TAG_WIDTH];
  assign w_rsp_in_data = {w_rsp_tag, rsp_texels_in};

  // Ready reflects only the addressed buffer, so one stalled requester
  // holds up the whole response bus.
  always_comb begin
    rsp_ready_in = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (w_rsp_sel == SEL_W'(i)) rsp_ready_in = w_rsp_buf_ready[i];
    end
  end

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_rsp
    logic             r_valid;
    logic             r_skid_valid;
    logic [RSP_W-1:0] r_data;
    logic [RSP_W-1:0] r_skid_data;

    assign w_rsp_in_valid[gi]  = rsp_valid_in && (w_rsp_sel == SEL_W'(gi));
    assign w_rsp_buf_ready[gi] = !r_skid_valid;
    assign w_rsp_fire[gi]      = w_rsp_in_valid[gi] && w_rsp_buf_ready[gi];

    // Same two-slot scheme as the request buffer, one per requester.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_valid      <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (!r_valid || rsp_ready_out[gi]) begin
        r_valid      <= r_skid_valid || w_rsp_fire[gi];
        r_skid_valid <= 1'b0;
      end else if (w_rsp_fire[gi]) begin
        r_skid_valid <= 1'b1;
      end
    end

    // Response payload registers.
    always_ff @(posedge clk) begin
      if (!r_valid || rsp_ready_out[gi]) begin
        r_data <= r_skid_valid ? r_skid_data : w_rsp_in_data;
      end else if (w_rsp_fire[gi]) begin
        r_skid_data <= w_rsp_in_data;
      end
    end

    assign rsp_valid_out[gi] = r_valid;
    assign {rsp_tag_out[gi*TAG_WIDTH +: TAG_WIDTH],
            rsp_texels_out[gi*NUM_LANES*32 +: NUM_LANES*32]} = r_data;

    tex_pending_ctr #(
      .MAX_PENDING (MAX_PENDING),
      .CNT_W       (CNT_W)
    ) u_pending_ctr (
      .clk    (clk),
      .reset  (reset),
      .i_inc  (req_ready_in[gi]),
      .i_dec  (w_rsp_fire[gi]),
      .o_full (w_full[gi])
    );
  end

endmodule
